// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with FLUSH and STALL.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered Ready_Out.
module pipe_stage_reg #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 5,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              STALL,
  input  logic              Valid_In,
  input  logic [CTRL_W-1:0] Ctrl_In,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Ready_Out,
  output logic              Valid_Out,
  output logic [CTRL_W-1:0] Ctrl_Out,
  output logic [DATA_W-1:0] Data_Out,
  input  logic              Ready_In
);

  logic ds_rdy;
  logic ds_xfer;
  logic up_xfer;

  assign ds_rdy  = Ready_In & ~STALL;
  assign ds_xfer = Valid_Out & ds_rdy;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_v;
  logic [CTRL_W-1:0] skid_c;
  logic [DATA_W-1:0] skid_d;

  assign Ready_Out = ~skid_v;
  assign up_xfer   = Valid_In & ~skid_v;

  // Output register: refill from skid on drain, else from input when free
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
      Data_Out  <= '0;
    end else if (FLUSH) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
    end else if (skid_v) begin
      if (ds_rdy) begin
        Ctrl_Out <= skid_c;
        Data_Out <= skid_d;
      end
    end else if (up_xfer && (!Valid_Out || ds_rdy)) begin
      Valid_Out <= 1'b1;
      Ctrl_Out  <= Ctrl_In;
      Data_Out  <= Data_In;
    end else if (ds_xfer) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
    end
  end

  // Skid entry: catches a word accepted while the output is full and held
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      skid_v <= 1'b0;
      skid_c <= CTRL_RST;
      skid_d <= '0;
    end else if (FLUSH) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (ds_rdy) skid_v <= 1'b0;
    end else if (up_xfer && Valid_Out && !ds_rdy) begin
      skid_v <= 1'b1;
      skid_c <= Ctrl_In;
      skid_d <= Data_In;
    end
  end

`else

  assign Ready_Out = ~Valid_Out | ds_rdy;
  assign up_xfer   = Valid_In & Ready_Out;

  // Single output register; bubbles clear valid/ctrl and keep data
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
      Data_Out  <= '0;
    end else if (FLUSH) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
    end else if (up_xfer) begin
      Valid_Out <= 1'b1;
      Ctrl_Out  <= Ctrl_In;
      Data_Out  <= Data_In;
    end else if (ds_xfer) begin
      Valid_Out <= 1'b0;
      Ctrl_Out  <= CTRL_RST;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg.
// Reference model is a FIFO of held words (capacity 1, or 2 with skid).
module tb_pipe_stage_reg;

  localparam int         DW   = 32;
  localparam int         CW   = 5;
  localparam logic [4:0] CRST = 5'h0A;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLOCK, RESET, FLUSH, STALL, Valid_In, Ready_In;
  logic [CW-1:0] Ctrl_In;
  logic [DW-1:0] Data_In;
  logic          Ready_Out, Valid_Out;
  logic [CW-1:0] Ctrl_Out;
  logic [DW-1:0] Data_Out;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .Valid_In(Valid_In), .Ctrl_In(Ctrl_In), .Data_In(Data_In),
    .Ready_Out(Ready_Out), .Valid_Out(Valid_Out),
    .Ctrl_Out(Ctrl_Out), .Data_Out(Data_Out), .Ready_In(Ready_In)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  word_t         q[$];
  logic [DW-1:0] last_d;
  int            errors = 0;
  int            checks = 0;

  function automatic bit m_ready();
    if (SKID) return q.size() < 2;
    return q.size() == 0 || (Ready_In && !STALL);
  endfunction

  function automatic bit m_valid();
    return q.size() > 0;
  endfunction

  function automatic logic [CW-1:0] m_ctrl();
    return (q.size() > 0) ? q[0].c : CRST;
  endfunction

  function automatic logic [DW-1:0] m_data();
    return (q.size() > 0) ? q[0].d : last_d;
  endfunction

  // advance one clock; model applies the rules to the pre-edge inputs
  task automatic cyc();
    bit    fl, rdy, pop, push;
    word_t w;
    fl   = FLUSH;
    rdy  = m_ready();
    pop  = q.size() > 0 && Ready_In && !STALL;
    push = Valid_In && rdy;
    w.c  = Ctrl_In;
    w.d  = Data_In;
    @(posedge CLOCK);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(w);
    end
    if (q.size() > 0) last_d = q[0].d;
    #1;
  endtask

  task automatic drive(bit v, logic [CW-1:0] c, logic [DW-1:0] d,
                       bit r, bit s, bit f);
    Valid_In = v; Ctrl_In = c; Data_In = d;
    Ready_In = r; STALL = s; FLUSH = f;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, 0, 0);
    RESET = 1'b1;
    #12;
    q.delete();
    last_d = '0;
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST || Data_Out !== '0) begin
      errors++;
      $display("FAIL reset_state v=%b c=%h d=%h want v=0 c=%h d=0",
               Valid_Out, Ctrl_Out, Data_Out, CRST);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    checks++;
    if (Ready_Out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b want=1", Ready_Out);
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'h11, DW'(i), 1, 0, 0);
      cyc();
      exp_d = DW'(i);
      checks++;
      if (Valid_Out !== 1'b1 || Data_Out !== exp_d ||
          Ctrl_Out !== 5'h11) begin
        errors++;
        $display("FAIL stream[%0d] v=%b c=%h d=%h want v=1 c=11 d=%h",
                 i, Valid_Out, Ctrl_Out, Data_Out, exp_d);
      end
    end
    drive(0, '0, '0, 1, 0, 0);
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST || Data_Out !== 32'h3) begin
      errors++;
      $display("FAIL stream_drain v=%b c=%h d=%h want v=0 c=%h d=3",
               Valid_Out, Ctrl_Out, Data_Out, CRST);
    end
  endtask

  task automatic test_stall();
    drive(1, 5'h13, 32'hA5, 1, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 32'hFF, 1, 1, 0);
      cyc();
      checks++;
      if (Valid_Out !== 1'b1 || Data_Out !== 32'hA5 ||
          Ctrl_Out !== 5'h13) begin
        errors++;
        $display("FAIL stall_hold[%0d] v=%b c=%h d=%h want v=1 c=13 d=a5",
                 i, Valid_Out, Ctrl_Out, Data_Out);
      end
    end
    drive(0, '0, '0, 1, 0, 0);
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST || Data_Out !== 32'hA5) begin
      errors++;
      $display("FAIL stall_release v=%b c=%h d=%h want v=0 c=%h d=a5",
               Valid_Out, Ctrl_Out, Data_Out, CRST);
    end
  endtask

  task automatic test_flush();
    drive(1, 5'h1F, 32'h77, 1, 0, 1);
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST) begin
      errors++;
      $display("FAIL flush_in v=%b c=%h want v=0 c=%h",
               Valid_Out, Ctrl_Out, CRST);
    end
    drive(1, 5'h1F, 32'h78, 0, 0, 0);
    cyc();
    drive(1, 5'h1E, 32'h79, 0, 1, 1);
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST) begin
      errors++;
      $display("FAIL flush_full v=%b c=%h want v=0 c=%h",
               Valid_Out, Ctrl_Out, CRST);
    end
    drive(0, '0, '0, 1, 0, 0);
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ready_Out !== 1'b1) begin
      errors++;
      $display("FAIL flush_after v=%b r=%b want v=0 r=1",
               Valid_Out, Ready_Out);
    end
  endtask

  task automatic test_backpressure();
    drive(0, '0, '0, 0, 0, 1);
    cyc();
    drive(1, 5'h01, 32'h10, 0, 0, 0);
    cyc();
    drive(1, 5'h02, 32'h20, 0, 0, 0);
    #1;
    checks++;
    if (Ready_Out !== SKID) begin
      errors++;
      $display("FAIL bp_ready_full got=%b want=%b", Ready_Out, SKID);
    end
    cyc();
    drive(0, '0, '0, 0, 0, 0);
    #1;
    checks++;
    if (Ready_Out !== 1'b0 || Data_Out !== 32'h10 || Valid_Out !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold r=%b v=%b d=%h want r=0 v=1 d=10",
               Ready_Out, Valid_Out, Data_Out);
    end
    Ready_In = 1'b1;
    cyc();
    checks++;
    if (SKID) begin
      if (Valid_Out !== 1'b1 || Data_Out !== 32'h20 ||
          Ctrl_Out !== 5'h02 || Ready_Out !== 1'b1) begin
        errors++;
        $display("FAIL bp_skid_drain v=%b c=%h d=%h r=%b want v=1 c=02 d=20 r=1",
                 Valid_Out, Ctrl_Out, Data_Out, Ready_Out);
      end
    end else begin
      if (Valid_Out !== 1'b0 || Data_Out !== 32'h10) begin
        errors++;
        $display("FAIL bp_drain v=%b d=%h want v=0 d=10",
                 Valid_Out, Data_Out);
      end
    end
    cyc();
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST) begin
      errors++;
      $display("FAIL bp_empty v=%b c=%h want v=0 c=%h",
               Valid_Out, Ctrl_Out, CRST);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
            $urandom_range(0, 24) == 0);
      #1;
      checks++;
      if (Ready_Out !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d] got=%b want=%b",
                 i, Ready_Out, m_ready());
      end
      cyc();
      checks++;
      if (Valid_Out !== m_valid() || Ctrl_Out !== m_ctrl() ||
          Data_Out !== m_data()) begin
        errors++;
        $display("FAIL rand_out[%0d] v=%b c=%h d=%h want v=%b c=%h d=%h",
                 i, Valid_Out, Ctrl_Out, Data_Out,
                 m_valid(), m_ctrl(), m_data());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 5'h05, 32'hBEEF, 0, 0, 0);
    cyc();
    drive(1, 5'h06, 32'hCAFE, 0, 0, 0);
    cyc();
    #2;
    RESET = 1'b1;
    #1;
    q.delete();
    last_d = '0;
    checks++;
    if (Valid_Out !== 1'b0 || Ctrl_Out !== CRST || Data_Out !== '0) begin
      errors++;
      $display("FAIL async_reset v=%b c=%h d=%h want v=0 c=%h d=0",
               Valid_Out, Ctrl_Out, Data_Out, CRST);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    drive(1, 5'h07, 32'h1234, 1, 0, 0);
    #1;
    checks++;
    if (Ready_Out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got=%b want=1", Ready_Out);
    end
    cyc();
    drive(0, '0, '0, 1, 0, 0);
    checks++;
    if (Valid_Out !== 1'b1 || Data_Out !== 32'h1234 ||
        Ctrl_Out !== 5'h07) begin
      errors++;
      $display("FAIL post_reset_word v=%b c=%h d=%h want v=1 c=07 d=1234",
               Valid_Out, Ctrl_Out, Data_Out);
    end
    cyc();
  endtask

  initial begin
    last_d = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the datapath payload.
REQ-002 SHALL have parameter CTRL_W, default 5, width of the control-bit bundle (RegWrite, Mem2Reg, MemWrite, Branch, Zero style enables).
REQ-003 SHALL have parameter CTRL_RST, default 0 (CTRL_W bits), bubble/reset value of control bits.
REQ-004 SHALL have port CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port FLUSH  in  1  synchronous kill of stage contents.
REQ-007 SHALL have port STALL  in  1  synchronous hold of stage contents.
REQ-008 SHALL have port Valid_In  in  1  upstream word valid.
REQ-009 SHALL have port Ctrl_In  in  CTRL_W  upstream control bits.
REQ-010 SHALL have port Data_In  in  DATA_W  upstream payload.
REQ-011 SHALL have port Ready_Out  out  1  stage can accept a word.
REQ-012 SHALL have port Valid_Out  out  1  stage holds a valid word.
REQ-013 SHALL have port Ctrl_Out  out  CTRL_W  registered control bits.
REQ-014 SHALL have port Data_Out  out  DATA_W  registered payload.
REQ-015 SHALL have port Ready_In  in  1  downstream can accept.

Function
REQ-016 SHALL accept an input word in a cycle where Valid_In=1 and Ready_Out=1 (upstream transfer).
REQ-017 SHALL treat downstream transfer as Valid_Out=1 and Ready_In=1 and STALL=0; effective downstream ready = Ready_In and not STALL.
REQ-018 SHALL present an accepted word on Valid_Out/Ctrl_Out/Data_Out one cycle after acceptance when the output register is empty or drains that cycle (latency 1).
REQ-019 SHALL hold Valid_Out, Ctrl_Out, Data_Out unchanged while Valid_Out=1 and effective downstream ready=0.
REQ-020 SHALL drive Ctrl_Out=CTRL_RST whenever Valid_Out=0 (bubble carries inactive enables); Data_Out value when Valid_Out=0 is don't-care but SHALL not change on bubbles.
REQ-021 SHALL sustain one transfer per cycle when Valid_In=1 and effective downstream ready=1 continuously.
REQ-022 SHALL preserve word order; no word duplicated or dropped except by FLUSH or RESET.
REQ-023 SHALL on a clock edge with FLUSH=1 clear all held words (Valid_Out<=0, Ctrl_Out<=CTRL_RST, skid entry emptied) and discard any word accepted that cycle; FLUSH has priority over STALL and handshakes.
REQ-024 SHALL with STALL=1 and FLUSH=0 still accept upstream only if storage is free per REQ-026/REQ-028.
REQ-025 SHALL update Valid_Out on simultaneous upstream and downstream transfer to the new word (valid stays 1).

Configuration
REQ-026 SHALL, without macro PIPE_STAGE_SKID_EN, use a single register entry and drive Ready_Out = not Valid_Out or effective downstream ready (combinational path from Ready_In/STALL).
REQ-027 SHALL, with PIPE_STAGE_SKID_EN defined, add one skid entry and drive Ready_Out from a register (Ready_Out = skid empty), no combinational path from Ready_In/STALL to Ready_Out.
REQ-028 SHALL in skid mode store an accepted word in the skid entry when the output register is full and not draining; Ready_Out deasserts the following cycle; on drain the skid word moves to the output register and Ready_Out reasserts next cycle.

Reset
REQ-029 SHALL on RESET=1, immediately and independent of CLOCK, set Valid_Out=0, Ctrl_Out=CTRL_RST, Data_Out=0, skid entry empty, Ready_Out=1 (both modes once RESET deasserts).
REQ-030 SHALL discard any in-flight word when RESET asserts mid-operation; first transfer after RESET deassertion behaves as from empty.

Verification
REQ-031 Stream Data_In=0x1,0x2,0x3 with Valid_In=1, Ready_In=1 -> Data_Out 0x1,0x2,0x3 on consecutive cycles one cycle later, Valid_Out=1 throughout.
REQ-032 Hold Valid_Out=1 with Data_Out=0xA5, raise STALL for 3 cycles -> Data_Out stays 0xA5, Ctrl_Out stable, released word transfers once on first cycle STALL=0.
REQ-033 FLUSH=1 with Valid_In=1, Ctrl_In=5'b11111 -> next cycle Valid_Out=0, Ctrl_Out=CTRL_RST, word never appears.
REQ-034 Skid mode: output full 0x10, Ready_In=0, send 0x20 -> Ready_Out=0 next cycle; raise Ready_In -> 0x10 then 0x20 in order, Ready_Out=1 again.
REQ-035 Assert RESET asynchronously mid-stream between edges -> Valid_Out=0, Ctrl_Out=CTRL_RST, Data_Out=0 immediately; after release, first accepted word appears after 1 cycle.
